ushift_burst_reg: RTL

- Universal shift register with a burst sequencer. It consumes the D-flip-flop stage output as its serial input.
- Supports hold, shift right, shift left and parallel load.
- A start pulse runs an autonomous WIDTH-bit serial shift-out with busy/done handshake.
- Sits directly downstream of the flip-flop conversion stages, on the same clk.

---
 rtl/ushift_pkg.sv | 19 +
 rtl/ushift_core.sv | 40 ++++
 rtl/ushift_burst_reg.sv | 109 ++++++++++
 3 files changed

// File: rtl/ushift_pkg.sv
// Shared encodings for the burst shift register: manual modes, burst direction and FSM states.
// Not synthesised on its own. Imported by ushift_core and ushift_burst_reg.
package ushift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/ushift_core.sv
// Mode-muxed WIDTH-bit register. It updates 1 clk after mode, fill and pin are sampled.
// There is no backpressure. An unknown or unlisted mode holds the contents.
module ushift_core
  import ushift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             fill_r,
  input  logic             fill_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_SHR:  q_d = {fill_r, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_l};
      MODE_LOAD: q_d = pin;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ushift_burst_reg.sv
// Universal shift register with a start-triggered WIDTH-bit burst. busy is high for WIDTH cycles, then done pulses for 1.
// start is ignored while a burst runs. When USHIFT_ROTATE_EN is defined, the burst rotates instead of filling from sin_r/sin_l.
module ushift_burst_reg
  import ushift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       core_mode;
  logic             fill_r;
  logic             fill_l;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    core_mode = MODE_HOLD;
    fill_r    = sin_r;
    fill_l    = sin_l;
    case (state_q)
      IDLE: begin
        // On a start edge, q holds and the manual mode is dropped.
        if (start) begin
          dir_d   = dir;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          core_mode = mode;
        end
      end
      SHIFT: begin
        core_mode = (dir_q == DIR_R) ? MODE_SHR : MODE_SHL;
`ifdef USHIFT_ROTATE_EN
        fill_r = q[0];
        fill_l = q[WIDTH-1];
`endif
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        core_mode = mode;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ushift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .clr    (clr),
    .mode   (core_mode),
    .fill_r (fill_r),
    .fill_l (fill_l),
    .pin    (pin),
    .q      (q)
  );

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
